max7219_chain_tx: RTL

MAX7219_CHAIN_TX -- requirements
Module: max7219_chain_tx

---
 rtl/max7219_pkg.sv | 28 ++
 rtl/max7219_chain_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain transmitter: register addresses
// and the transmitter state encoding.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP         = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
  localparam logic [3:0] ADDR_DECODE_MODE  = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LOW,
    ST_SHIFT_HIGH,
    ST_LOAD,
    ST_DONE
  } max7219_tx_state_t;

endpackage

// File: rtl/max7219_chain_tx.sv
// Serialises one 16-bit word per cascaded MAX7219 (farthest device first)
// and strobes LOAD once the whole chain has been shifted.
module max7219_chain_tx
  import max7219_pkg::*;
#(
  parameter int G_MATRIX_NB   = 8,
  parameter int G_CLK_DIV     = 4,
  parameter int G_LOAD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_frame_valid,
  input  logic [16*G_MATRIX_NB-1:0] i_frame_data,
  output logic                      o_frame_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load
);

  localparam int W_FRAME = 16 * G_MATRIX_NB;
  localparam int W_BIT   = $clog2(W_FRAME);
  localparam int DIV_MAX = (G_CLK_DIV > G_LOAD_CYCLES) ? G_CLK_DIV : G_LOAD_CYCLES;
  localparam int W_DIV   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [W_BIT-1:0] BIT_TOP   = W_BIT'(W_FRAME - 1);
  localparam logic [W_DIV-1:0] DIV_LAST  = W_DIV'(G_CLK_DIV - 1);
  localparam logic [W_DIV-1:0] LOAD_LAST = W_DIV'(G_LOAD_CYCLES - 1);

  max7219_tx_state_t  r_state, w_state_nxt;
  logic [W_FRAME-1:0] r_shift, w_shift_nxt;
  logic [W_BIT-1:0]   r_bit,   w_bit_nxt;
  logic [W_DIV-1:0]   r_div,   w_div_nxt;
  logic               r_sclk, r_din, r_load, r_done, r_busy, r_ready;
  logic               w_shifting;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    unique case (r_state)
      ST_IDLE: begin
        if (i_frame_valid) begin
          w_state_nxt = ST_SHIFT_LOW;
          w_shift_nxt = i_frame_data;
          w_bit_nxt   = BIT_TOP;
          w_div_nxt   = '0;
        end
      end
      ST_SHIFT_LOW: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt   = '0;
          w_state_nxt = ST_SHIFT_HIGH;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_SHIFT_HIGH: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (r_bit == '0) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_bit_nxt   = r_bit - 1'b1;
            w_shift_nxt = {r_shift[W_FRAME-2:0], 1'b0};
            w_state_nxt = ST_SHIFT_LOW;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_LOAD: begin
        if (r_div == LOAD_LAST) begin
          w_div_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_shift_nxt = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the serial pins come straight off flops.
  assign w_shifting = (w_state_nxt == ST_SHIFT_LOW) || (w_state_nxt == ST_SHIFT_HIGH);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_din   <= 1'b0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      r_sclk  <= (w_state_nxt == ST_SHIFT_HIGH);
      r_din   <= w_shifting & w_shift_nxt[W_FRAME-1];
      r_load  <= (w_state_nxt == ST_LOAD);
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign o_frame_ready  = r_ready;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_max7219_clk  = r_sclk;
  assign o_max7219_din  = r_din;
  assign o_max7219_load = r_load;

endmodule
